// File: rtl/frame_bank_pkg.sv
// Shared types for the triple-buffer frame bank scheduler: bank index and FSM states.
package frame_bank_pkg;

   localparam int NUM_BANKS = 3;
   localparam int BANK_W    = 2;

   typedef logic [BANK_W-1:0] bank_t;

   typedef enum logic [1:0] {
      ST_INIT,
      ST_ARM,
      ST_RUN
   } state_t;

endpackage

// File: rtl/frame_bank_pick.sv
// Combinational pick of the lowest-numbered bank that is neither displayed nor
// holding a pending (valid) completed frame.
module frame_bank_pick
   import frame_bank_pkg::*;
(
   input  logic [BANK_W-1:0] excl_a,
   input  logic [BANK_W-1:0] excl_b,
   input  logic              excl_b_valid,
   output logic [BANK_W-1:0] free_bank
);

   // Descending scan so the lowest eligible index is the last one written.
   always_comb begin
      free_bank = '0;
      for (int i = NUM_BANKS - 1; i >= 0; i--) begin
         if ((bank_t'(i) != excl_a) && !(excl_b_valid && (bank_t'(i) == excl_b))) begin
            free_bank = bank_t'(i);
         end
      end
   end

endmodule

// File: rtl/frame_bank_scheduler.sv
// Triple-buffer scheduler: hands the camera writer and VGA reader disjoint SDRAM
// frame banks, drives WR1/RD1 address/max/load and counts dropped/repeated frames.
module frame_bank_scheduler
   import frame_bank_pkg::*;
#(
   parameter int ADDR_W      = 23,
   parameter int BASE_ADDR   = 0,
   parameter int BANK_STRIDE = 524288,
   parameter int FRAME_WORDS = 307200,
   parameter int CNT_W       = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              init_busy,
   input  logic              wr_frame_pulse,
   input  logic              rd_frame_pulse,
   input  logic              freeze,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [ADDR_W-1:0] wr_max_addr,
   output logic              wr_load,
   output logic [ADDR_W-1:0] rd_addr,
   output logic [ADDR_W-1:0] rd_max_addr,
   output logic              rd_load,
   output logic [BANK_W-1:0] wr_bank,
   output logic [BANK_W-1:0] rd_bank,
   output logic              ready_valid,
   output logic [CNT_W-1:0]  drop_cnt,
   output logic [CNT_W-1:0]  repeat_cnt
);

   localparam logic [ADDR_W-1:0] BASE_A   = ADDR_W'(BASE_ADDR);
   localparam logic [ADDR_W-1:0] STRIDE_A = ADDR_W'(BANK_STRIDE);
   localparam logic [ADDR_W-1:0] FRAME_A  = ADDR_W'(FRAME_WORDS);

   localparam bank_t RST_WR_BANK    = bank_t'(0);
   localparam bank_t RST_RD_BANK    = bank_t'(1);
   localparam bank_t RST_READY_BANK = bank_t'(2);

   function automatic logic [ADDR_W-1:0] bank_base(input logic [BANK_W-1:0] b);
      return BASE_A + ADDR_W'(b) * STRIDE_A;
   endfunction

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
   endfunction

   localparam logic [ADDR_W-1:0] RST_WR_ADDR = BASE_A;
   localparam logic [ADDR_W-1:0] RST_RD_ADDR = BASE_A + STRIDE_A;

   state_t              state_q, state_d;
   logic [BANK_W-1:0]   wr_bank_q, wr_bank_d;
   logic [BANK_W-1:0]   rd_bank_q, rd_bank_d;
   logic [BANK_W-1:0]   ready_bank_q, ready_bank_d;
   logic                ready_valid_q, ready_valid_d;
   logic [CNT_W-1:0]    drop_q, drop_d;
   logic [CNT_W-1:0]    repeat_q, repeat_d;
   logic                wr_pend_q, wr_pend_d;
   logic                rd_pend_q, rd_pend_d;
   logic                wr_load_q, wr_load_d;
   logic                rd_load_q, rd_load_d;
   logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
   logic [ADDR_W-1:0]   wr_max_q, wr_max_d;
   logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
   logic [ADDR_W-1:0]   rd_max_q, rd_max_d;
   logic                wr_take;
   logic [BANK_W-1:0]   pick_bank;

   // Write completion is applied before the read so a simultaneous read picks up
   // the frame that just finished; the pend flags delay each load by one cycle.
   always_comb begin
      state_d       = state_q;
      rd_bank_d     = rd_bank_q;
      ready_bank_d  = ready_bank_q;
      ready_valid_d = ready_valid_q;
      drop_d        = drop_q;
      repeat_d      = repeat_q;
      wr_pend_d     = 1'b0;
      rd_pend_d     = 1'b0;

      if (init_busy) begin
         state_d       = ST_INIT;
         rd_bank_d     = RST_RD_BANK;
         ready_bank_d  = RST_READY_BANK;
         ready_valid_d = 1'b0;
         drop_d        = '0;
         repeat_d      = '0;
      end else begin
         case (state_q)
            ST_INIT: state_d = ST_ARM;
            ST_ARM:  state_d = ST_RUN;
            ST_RUN: begin
               wr_pend_d = wr_frame_pulse;
               rd_pend_d = rd_frame_pulse;
               if (wr_frame_pulse) begin
                  if (ready_valid_q) begin
                     drop_d = sat_inc(drop_q);
                  end
                  ready_bank_d  = wr_bank_q;
                  ready_valid_d = 1'b1;
               end
               if (rd_frame_pulse) begin
                  if (ready_valid_d && !freeze) begin
                     rd_bank_d     = ready_bank_d;
                     ready_valid_d = 1'b0;
                  end else begin
                     repeat_d = sat_inc(repeat_q);
                  end
               end
            end
            default: state_d = ST_INIT;
         endcase
      end

      wr_load_d = (state_d == ST_INIT) || wr_pend_q;
      rd_load_d = (state_d == ST_INIT) || rd_pend_q;
   end

   assign wr_take = !init_busy && (state_q == ST_RUN) && wr_frame_pulse;

   frame_bank_pick u_pick (
      .excl_a       (rd_bank_d),
      .excl_b       (ready_bank_d),
      .excl_b_valid (ready_valid_d),
      .free_bank    (pick_bank)
   );

   always_comb begin
      wr_bank_d = wr_bank_q;
      if (init_busy) begin
         wr_bank_d = RST_WR_BANK;
      end else if (wr_take) begin
         wr_bank_d = pick_bank;
      end
   end

   assign wr_addr_d = bank_base(wr_bank_d);
   assign wr_max_d  = wr_addr_d + FRAME_A;
   assign rd_addr_d = bank_base(rd_bank_d);
   assign rd_max_d  = rd_addr_d + FRAME_A;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_INIT;
         wr_bank_q     <= RST_WR_BANK;
         rd_bank_q     <= RST_RD_BANK;
         ready_bank_q  <= RST_READY_BANK;
         ready_valid_q <= 1'b0;
         drop_q        <= '0;
         repeat_q      <= '0;
         wr_pend_q     <= 1'b0;
         rd_pend_q     <= 1'b0;
         wr_load_q     <= 1'b1;
         rd_load_q     <= 1'b1;
         wr_addr_q     <= RST_WR_ADDR;
         wr_max_q      <= RST_WR_ADDR + FRAME_A;
         rd_addr_q     <= RST_RD_ADDR;
         rd_max_q      <= RST_RD_ADDR + FRAME_A;
      end else begin
         state_q       <= state_d;
         wr_bank_q     <= wr_bank_d;
         rd_bank_q     <= rd_bank_d;
         ready_bank_q  <= ready_bank_d;
         ready_valid_q <= ready_valid_d;
         drop_q        <= drop_d;
         repeat_q      <= repeat_d;
         wr_pend_q     <= wr_pend_d;
         rd_pend_q     <= rd_pend_d;
         wr_load_q     <= wr_load_d;
         rd_load_q     <= rd_load_d;
         wr_addr_q     <= wr_addr_d;
         wr_max_q      <= wr_max_d;
         rd_addr_q     <= rd_addr_d;
         rd_max_q      <= rd_max_d;
      end
   end

   assign wr_addr     = wr_addr_q;
   assign wr_max_addr = wr_max_q;
   assign wr_load     = wr_load_q;
   assign rd_addr     = rd_addr_q;
   assign rd_max_addr = rd_max_q;
   assign rd_load     = rd_load_q;
   assign wr_bank     = wr_bank_q;
   assign rd_bank     = rd_bank_q;
   assign ready_valid = ready_valid_q;
   assign drop_cnt    = drop_q;
   assign repeat_cnt  = repeat_q;

endmodule

// File: tb/tb_frame_bank_scheduler.sv
// Self-checking bench for frame_bank_scheduler: directed vector table plus
// hand-written sequences for init, counter saturation and mid-run re-init.
module tb_frame_bank_scheduler;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        init_busy;
   logic        wr_frame_pulse;
   logic        rd_frame_pulse;
   logic        freeze;
   logic [22:0] wr_addr, wr_max_addr, rd_addr, rd_max_addr;
   logic        wr_load, rd_load, ready_valid;
   logic [1:0]  wr_bank, rd_bank;
   logic [15:0] drop_cnt, repeat_cnt;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic busy;
      logic wrp;
      logic rdp;
      logic frz;
      int   e_wr;
      int   e_rd;
      logic e_v;
      int   e_drop;
      int   e_rep;
      logic e_wl;
      logic e_rl;
   } vec_t;

   vec_t vecs[$];

   frame_bank_scheduler dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .init_busy      (init_busy),
      .wr_frame_pulse (wr_frame_pulse),
      .rd_frame_pulse (rd_frame_pulse),
      .freeze         (freeze),
      .wr_addr        (wr_addr),
      .wr_max_addr    (wr_max_addr),
      .wr_load        (wr_load),
      .rd_addr        (rd_addr),
      .rd_max_addr    (rd_max_addr),
      .rd_load        (rd_load),
      .wr_bank        (wr_bank),
      .rd_bank        (rd_bank),
      .ready_valid    (ready_valid),
      .drop_cnt       (drop_cnt),
      .repeat_cnt     (repeat_cnt)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
      end
   endtask

   // Inputs change on the falling edge; outputs are sampled on the next falling edge.
   task automatic applyStimulus(input logic busy, input logic wrp, input logic rdp, input logic frz);
      init_busy      = busy;
      wr_frame_pulse = wrp;
      rd_frame_pulse = rdp;
      freeze         = frz;
      @(negedge clk);
   endtask

   task automatic checkState(input string tag, input int e_wr, input int e_rd, input logic e_v,
                             input int e_drop, input int e_rep, input logic e_wl, input logic e_rl);
      checkOutput({tag, " wr_bank"},     32'(wr_bank),     32'(e_wr));
      checkOutput({tag, " rd_bank"},     32'(rd_bank),     32'(e_rd));
      checkOutput({tag, " ready_valid"}, 32'(ready_valid), 32'(e_v));
      checkOutput({tag, " drop_cnt"},    32'(drop_cnt),    32'(e_drop));
      checkOutput({tag, " repeat_cnt"},  32'(repeat_cnt),  32'(e_rep));
      checkOutput({tag, " wr_load"},     32'(wr_load),     32'(e_wl));
      checkOutput({tag, " rd_load"},     32'(rd_load),     32'(e_rl));
      checkOutput({tag, " wr_addr"},     32'(wr_addr),     32'(e_wr * 524288));
      checkOutput({tag, " wr_max_addr"}, 32'(wr_max_addr), 32'(e_wr * 524288 + 307200));
      checkOutput({tag, " rd_addr"},     32'(rd_addr),     32'(e_rd * 524288));
      checkOutput({tag, " rd_max_addr"}, 32'(rd_max_addr), 32'(e_rd * 524288 + 307200));
   endtask

   function automatic void addVec(input logic busy, input logic wrp, input logic rdp, input logic frz,
                                  input int e_wr, input int e_rd, input logic e_v, input int e_drop,
                                  input int e_rep, input logic e_wl, input logic e_rl);
      vec_t v;
      v.busy = busy; v.wrp = wrp; v.rdp = rdp; v.frz = frz;
      v.e_wr = e_wr; v.e_rd = e_rd; v.e_v = e_v; v.e_drop = e_drop;
      v.e_rep = e_rep; v.e_wl = e_wl; v.e_rl = e_rl;
      vecs.push_back(v);
   endfunction

   initial begin
      // Expected state after each cycle; a pulse's load shows one row later.
      addVec(0,0,0,0, 0,1,0,0,0, 0,0);
      addVec(0,0,0,0, 0,1,0,0,0, 0,0);
      addVec(0,1,0,0, 2,1,1,0,0, 0,0);
      addVec(0,0,0,0, 2,1,1,0,0, 1,0);
      for (int i = 0; i < 9; i++) addVec(0,0,0,0, 2,1,1,0,0, 0,0);
      addVec(0,0,1,0, 2,0,0,0,0, 0,0);
      addVec(0,0,0,0, 2,0,0,0,0, 0,1);
      addVec(0,0,0,0, 2,0,0,0,0, 0,0);
      addVec(0,1,0,0, 1,0,1,0,0, 0,0);
      addVec(0,1,0,0, 2,0,1,1,0, 1,0);
      addVec(0,1,0,0, 1,0,1,2,0, 1,0);
      addVec(0,0,0,0, 1,0,1,2,0, 1,0);
      addVec(0,0,0,0, 1,0,1,2,0, 0,0);
      addVec(0,0,1,0, 1,2,0,2,0, 0,0);
      addVec(0,1,1,0, 0,1,0,2,0, 0,1);
      addVec(0,1,1,0, 1,0,0,2,0, 1,1);
      addVec(0,0,0,0, 1,0,0,2,0, 1,1);
      addVec(0,0,0,0, 1,0,0,2,0, 0,0);
      addVec(0,1,0,1, 2,0,1,2,0, 0,0);
      addVec(0,0,0,1, 2,0,1,2,0, 1,0);
      addVec(0,0,1,1, 2,0,1,2,1, 0,0);
      addVec(0,0,0,1, 2,0,1,2,1, 0,1);
      addVec(0,0,0,1, 2,0,1,2,1, 0,0);
      addVec(0,0,0,1, 2,0,1,2,1, 0,0);

      rst_n          = 1'b0;
      init_busy      = 1'b1;
      wr_frame_pulse = 1'b0;
      rd_frame_pulse = 1'b0;
      freeze         = 1'b0;
      repeat (2) @(negedge clk);
      checkState("reset", 0, 1, 0, 0, 0, 1, 1);
      rst_n = 1'b1;

      for (int i = 0; i < 100; i++) begin
         applyStimulus(1, (i % 7) == 3, (i % 11) == 5, 0);
         checkState($sformatf("init%0d", i), 0, 1, 0, 0, 0, 1, 1);
      end

      foreach (vecs[i]) begin
         applyStimulus(vecs[i].busy, vecs[i].wrp, vecs[i].rdp, vecs[i].frz);
         checkState($sformatf("vec%0d", i), vecs[i].e_wr, vecs[i].e_rd, vecs[i].e_v,
                    vecs[i].e_drop, vecs[i].e_rep, vecs[i].e_wl, vecs[i].e_rl);
      end

      for (int i = 0; i < 65534; i++) applyStimulus(0, 0, 1, 1);
      checkOutput("sat_reach repeat_cnt", 32'(repeat_cnt), 32'd65535);
      for (int i = 0; i < 6; i++) applyStimulus(0, 0, 1, 1);
      checkState("sat_hold", 2, 0, 1, 2, 65535, 0, 1);
      applyStimulus(0, 0, 0, 0);
      checkState("sat_idle", 2, 0, 1, 2, 65535, 0, 1);

      applyStimulus(1, 1, 1, 0);
      checkState("reinit0", 0, 1, 0, 0, 0, 1, 1);
      applyStimulus(1, 1, 0, 0);
      checkState("reinit1", 0, 1, 0, 0, 0, 1, 1);
      applyStimulus(0, 0, 0, 0);
      checkState("rearm", 0, 1, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0);
      checkState("rerun", 0, 1, 0, 0, 0, 0, 0);
      applyStimulus(0, 1, 0, 0);
      checkState("rewr", 2, 1, 1, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0);
      checkState("rewr_load", 2, 1, 1, 0, 0, 1, 0);
      applyStimulus(0, 0, 0, 0);
      checkState("rewr_done", 2, 1, 1, 0, 0, 0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
